// File: rtl/lcd_message_writer.sv
// lcd_message_writer: latches a 32-character frame and writes it to a 16x2 HD44780-style LCD
// over an 8-bit parallel bus. Handles power-up wait, init commands and all bus timing.
// Optional feature: define LCD_AUTO_REFRESH_EN to redraw automatically after REFRESH_CYCLES
// idle cycles.
module lcd_message_writer #(
    parameter int unsigned PWRUP_CYCLES      = 800000,
    parameter int unsigned E_CYCLES          = 12,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
`ifdef LCD_AUTO_REFRESH_EN
    ,
    parameter int unsigned REFRESH_CYCLES    = 2500000
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] message,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_data
);

    typedef enum logic [3:0] {
        StPwrup, StInit, StIdle, StLatch, StAddr1, StChr1, StAddr2, StChr2, StDone
    } state_e;

    typedef enum logic [1:0] {PhSetup, PhEnable, PhWait} phase_e;

    state_e         state_q, state_d;
    phase_e         phase_q, phase_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [4:0]     idx_q, idx_d;
    logic           pending_q, pending_d;
    logic [255:0]   frame_q, frame_d;
    logic           rs_q, rs_d;
    logic [7:0]     data_q, data_d;
    logic           e_q, e_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [31:0]    wait_len;
    logic           tx_done;
    logic           refresh_hit;
    logic           load_tx;
    logic           tx_rs;
    logic           tx_is_char;
    logic [7:0]     tx_byte;

    function automatic logic is_tx(input state_e s);
        return (s == StInit) || (s == StAddr1) || (s == StChr1) || (s == StAddr2) ||
               (s == StChr2);
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        unique case (i)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = 8'h01;
            default: c = 8'h06;
        endcase
        return c;
    endfunction

    // Clear needs the long settle time; a 0x01 character (rs=1) does not.
    assign wait_len = (!rs_q && data_q == 8'h01) ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;
    assign tx_done  = (phase_q == PhWait) && (cnt_q == wait_len - 32'd1);

`ifdef LCD_AUTO_REFRESH_EN
    logic [31:0] refresh_q, refresh_d;

    assign refresh_hit = (state_q == StIdle) && (refresh_q == REFRESH_CYCLES - 32'd1);

    // Idle-cycle counter for auto refresh; cleared whenever the FSM leaves IDLE.
    always_comb begin
        refresh_d = 32'd0;
        if (state_q == StIdle && state_d == StIdle) begin
            refresh_d = refresh_q + 32'd1;
        end
    end

    // Refresh counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= 32'd0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // Next-state logic: main FSM, transaction phase sequencer and registered outputs.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        rs_d       = rs_q;
        data_d     = data_q;
        load_tx    = 1'b0;
        tx_rs      = 1'b0;
        tx_is_char = 1'b0;
        tx_byte    = 8'h00;

        // A start that cannot be served right now is remembered once.
        pending_d = pending_q;
        if (state_q == StLatch) begin
            pending_d = 1'b0;
        end
        if (start && state_q != StIdle) begin
            pending_d = 1'b1;
        end

        // Setup -> enable (E_CYCLES) -> wait; completion is handled per state below.
        if (is_tx(state_q)) begin
            unique case (phase_q)
                PhSetup: begin
                    phase_d = PhEnable;
                    cnt_d   = 32'd0;
                end
                PhEnable: begin
                    if (cnt_q == E_CYCLES - 32'd1) begin
                        phase_d = PhWait;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: cnt_d = cnt_q + 32'd1;
            endcase
        end

        unique case (state_q)
            StPwrup: begin
                if (cnt_q == PWRUP_CYCLES - 32'd1) begin
                    state_d = StInit;
                    idx_d   = 5'd0;
                    load_tx = 1'b1;
                    tx_byte = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StInit: begin
                if (tx_done) begin
                    if (idx_q[1:0] == 2'd3) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        load_tx = 1'b1;
                        tx_byte = init_cmd(idx_q[1:0] + 2'd1);
                    end
                end
            end
            StIdle: begin
                if (start || pending_q || refresh_hit) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                frame_d = message;
                state_d = StAddr1;
                load_tx = 1'b1;
                tx_byte = 8'h80;
            end
            StAddr1: begin
                if (tx_done) begin
                    state_d    = StChr1;
                    idx_d      = 5'd0;
                    load_tx    = 1'b1;
                    tx_is_char = 1'b1;
                end
            end
            StChr1: begin
                if (tx_done) begin
                    load_tx = 1'b1;
                    if (idx_q == 5'd15) begin
                        state_d = StAddr2;
                        tx_byte = 8'hC0;
                    end else begin
                        idx_d      = idx_q + 5'd1;
                        tx_is_char = 1'b1;
                    end
                end
            end
            StAddr2: begin
                if (tx_done) begin
                    state_d    = StChr2;
                    idx_d      = 5'd16;
                    load_tx    = 1'b1;
                    tx_is_char = 1'b1;
                end
            end
            StChr2: begin
                if (tx_done) begin
                    // Index stops at 31; never wraps past the last character.
                    if (idx_q == 5'd31) begin
                        state_d = StDone;
                    end else begin
                        idx_d      = idx_q + 5'd1;
                        load_tx    = 1'b1;
                        tx_is_char = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (tx_is_char) begin
            tx_rs   = 1'b1;
            tx_byte = frame_q[{idx_d, 3'b000} +: 8];
        end

        if (load_tx) begin
            phase_d = PhSetup;
            cnt_d   = 32'd0;
            rs_d    = tx_rs;
            data_d  = tx_byte;
        end

        e_d    = is_tx(state_d) && (phase_d == PhEnable);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StPwrup;
            phase_q   <= PhSetup;
            cnt_q     <= 32'd0;
            idx_q     <= 5'd0;
            pending_q <= 1'b0;
            frame_q   <= '0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            e_q       <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            e_q       <= e_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = e_q;
    assign lcd_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lcd_message_writer.sv
// Bench for lcd_message_writer: expected bus bytes are queued when a redraw/init is triggered
// and compared on every rising lcd_e. Checks init/redraw timing, pending collapse, frame
// latching and asynchronous reset.
module tb_lcd_message_writer;

    localparam int unsigned PWRUP = 20;
    localparam int unsigned ECYC  = 2;
    localparam int unsigned CMDW  = 4;
    localparam int unsigned CLRW  = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [255:0] message = '0;
    logic         start = 1'b0;
    logic         busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]   lcd_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int done_cnt = 0;
    int hi = 0;
    logic e_prev = 1'b0;
    int rise_log[$];
    logic [8:0] exp_q[$];

    lcd_message_writer #(
        .PWRUP_CYCLES      (PWRUP),
        .E_CYCLES          (ECYC),
        .CMD_WAIT_CYCLES   (CMDW),
        .CLEAR_WAIT_CYCLES (CLRW)
`ifdef LCD_AUTO_REFRESH_EN
        ,
        .REFRESH_CYCLES    (50)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .message  (message),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: pops the scoreboard on each lcd_e rise and checks enable width.
    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev = 1'b0;
            hi     = 0;
        end else begin
            if (done) done_cnt++;
            if (lcd_e && !e_prev) begin
                rise_cnt++;
                rise_log.push_back(cyc);
                check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("tx_byte", 32'({lcd_rs, lcd_data}), 32'(exp_q.pop_front()));
                end
            end
            if (lcd_e) begin
                hi++;
            end else if (e_prev) begin
                check("e_width", 32'(hi), 32'(ECYC));
                hi = 0;
            end
            e_prev = lcd_e;
        end
    end

    function automatic logic [255:0] str2msg(input string s);
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m[8*i +: 8] = s[i];
        return m;
    endfunction

    task automatic push_frame(input logic [255:0] m);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, m[8*i +: 8]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, m[8*i +: 8]});
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Releases reset and checks the power-up wait and the four init transactions.
    task automatic init_check();
        int n0, rel, idle_cyc;
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        n0 = rise_log.size();
        @(negedge clk);
        rel   = cyc;
        rst_n = 1'b1;
        idle_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
        end
        check("init_idle", 32'(busy), 32'd0);
        check("init_tx_count", 32'(rise_log.size() - n0), 32'd4);
        if (rise_log.size() - n0 == 4) begin
            check("init_first_e", 32'(rise_log[n0] - rel), 32'(PWRUP + 1));
            check("init_gap_38", 32'(rise_log[n0+1] - rise_log[n0]), 32'(1 + ECYC + CMDW));
            check("init_gap_0c", 32'(rise_log[n0+2] - rise_log[n0+1]), 32'(1 + ECYC + CMDW));
            check("init_gap_clr", 32'(rise_log[n0+3] - rise_log[n0+2]), 32'(1 + ECYC + CLRW));
            check("init_busy_fall", 32'(idle_cyc - rise_log[n0+3]), 32'(ECYC + CMDW));
        end
        check("init_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] msg_a, msg_b, msg_c;
        int n, d0, r0, busy_seen;

        msg_a = str2msg("NS:0012 SN:0034 EW:0005 WE:0100 ");
        for (int i = 0; i < 32; i++) msg_b[8*i +: 8] = 8'(i * 37 + 1);
        msg_b[8*5 +: 8] = 8'hFF;
        msg_c = ~msg_b;

        // Reset values.
        #2 rst_n = 1'b0;
        #1;
        check("rst_e", 32'(lcd_e), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_data", 32'(lcd_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);

        // Scenario 1: power-up and init.
        init_check();

        // Scenario 2: single redraw, 34 transactions then done.
        message = msg_a;
        push_frame(msg_a);
        pulse_start();
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 n++;
            if (done) break;
        end
        check("redraw_cycles", 32'(n), 32'd239);
        check("done_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("done_pulse_width", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("redraw_queue_empty", 32'(exp_q.size()), 32'd0);

        // Scenario 3: three starts during a redraw collapse into one extra redraw.
        d0 = done_cnt;
        push_frame(msg_a);
        push_frame(msg_a);
        pulse_start();
        repeat (40) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            repeat (20) @(posedge clk);
        end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done_cnt == d0 + 2) break;
        end
        repeat (40) @(negedge clk);
        check("pending_redraws", 32'(done_cnt - d0), 32'd2);
        check("pending_idle", 32'(busy), 32'd0);
        check("pending_queue_empty", 32'(exp_q.size()), 32'd0);

        // Scenario 4: frame is latched; 0x01/0xFF chars use normal timing.
        message = msg_b;
        push_frame(msg_b);
        pulse_start();
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 n++;
            if (n == 3) message = msg_c;
            if (done) break;
        end
        check("latched_cycles", 32'(n), 32'd239);
        check("latched_queue_empty", 32'(exp_q.size()), 32'd0);

        // Scenario 5: reset while lcd_e is high during line 2.
        push_frame(msg_c);
        r0 = rise_cnt;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rise_cnt == r0 + 21) break;
        end
        check("chr2_e_high", 32'(lcd_e), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midtx_rst_e", 32'(lcd_e), 32'd0);
        check("midtx_rst_data", 32'(lcd_data), 32'd0);
        check("midtx_rst_busy", 32'(busy), 32'd1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        init_check();

        // Scenario 6: idle behaviour.
`ifdef LCD_AUTO_REFRESH_EN
        push_frame(msg_c);
        push_frame(msg_c);
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) break;
        end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (busy) break;
        end
        check("refresh_delay", 32'(n), 32'd51);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_cnt == d0 + 2) break;
        end
        check("refresh_queue_empty", 32'(exp_q.size()), 32'd0);
`else
        r0 = rise_cnt;
        busy_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("no_auto_busy", 32'(busy_seen), 32'd0);
        check("no_auto_tx", 32'(rise_cnt - r0), 32'd0);
`endif
        check("rw_low", 32'(lcd_rw), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
